// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store unit with a single-outstanding data-memory handshake.
// Tracks one access through IDLE/WAIT/DONE, bounds the wait with a timeout, and extends load data.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_me,
  input  logic [5:0]  op_me,
  input  logic [31:0] Result_me,
  input  logic [31:0] wdata_me,
  output logic        stall_me,
  output logic [31:0] Do_me,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   do_q, do_d;
  logic          bus_err_q, bus_err_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [5:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;

  logic        is_load, is_store, misaligned, in_idle, start;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    is_load    = (op_me == OP_LB) || (op_me == OP_LH) || (op_me == OP_LW) ||
                 (op_me == OP_LBU) || (op_me == OP_LHU);
    is_store   = (op_me == OP_SB) || (op_me == OP_SH) || (op_me == OP_SW);
    misaligned = (((op_me == OP_LW) || (op_me == OP_SW)) && (Result_me[1:0] != 2'b00)) ||
                 (((op_me == OP_LH) || (op_me == OP_LHU) || (op_me == OP_SH)) && Result_me[0]);
    in_idle    = (state_q == S_IDLE);
    start      = in_idle && valid_me && (is_load || is_store) && !misaligned;
    adel       = in_idle && valid_me && is_load && misaligned;
    ades       = in_idle && valid_me && is_store && misaligned;
    stall_me   = start || (state_q == S_WAIT);
  end

  // Loads always fetch the whole word; the lane is picked when the reply lands.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_me;
    if (is_store) begin
      case (op_me[1:0])
        2'b00: begin
          be_new    = 4'b0001 << Result_me[1:0];
          wdata_new = {4{wdata_me[7:0]}};
        end
        2'b01: begin
          be_new    = Result_me[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{wdata_me[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = wdata_me;
        end
      endcase
    end
  end

  always_comb begin
    rd_byte = 8'(dm_rdata >> {off_q, 3'b000});
    rd_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'h0, rd_byte};
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'h0, rd_half};
      default: load_val = dm_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_d      = do_q;
    bus_err_d = bus_err_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    off_d     = off_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {Result_me[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          op_d    = op_me;
          off_d   = Result_me[1:0];
        end
      end
      S_WAIT: begin
        if (dm_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) do_d = load_val;
        end else if (cnt_q == LAST) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
          if (!we_q) do_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bus_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      do_q      <= 32'h0;
      bus_err_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      op_q      <= 6'h0;
      off_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      do_q      <= do_d;
      bus_err_q <= bus_err_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      off_q     <= off_d;
    end
  end

  assign Do_me    = do_q;
  assign bus_err  = bus_err_q;
  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_be    = be_q;
  assign dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized and directed checks of mem_access against a transaction-level model.
module tb_mem_access;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_me = 1'b0;
  logic [5:0]  op_me = 6'h0;
  logic [31:0] Result_me = 32'h0;
  logic [31:0] wdata_me = 32'h0;
  logic        stall_me, adel, ades, bus_err, dm_req, dm_we;
  logic [31:0] Do_me, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_do = 32'h0;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_me(valid_me), .op_me(op_me), .Result_me(Result_me),
    .wdata_me(wdata_me), .stall_me(stall_me), .Do_me(Do_me), .adel(adel), .ades(ades),
    .bus_err(bus_err), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes; 0 for anything that is not a memory op.
  function automatic int op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21);
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] rd);
    longint raw, span;
    span = longint'(1) << (8 * op_size(op));
    raw  = (longint'(rd) >> (8 * (a % 4))) % span;
    if (op_signed(op) && raw >= span / 2) raw = raw - span;
    return 32'(raw);
  endfunction

  function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] a);
    int sz = op_size(op);
    if (!op_is_store(op) || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << (a % 4));
    return (a % 4 >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] rt);
    case (op_size(op))
      1:       return (rt % 256) * 32'h01010101;
      2:       return (rt % 65536) * 32'h00010001;
      default: return rt;
    endcase
  endfunction

  // One instruction in MEM; ack_at is the 0-based WAIT cycle of the reply, >= TO means never.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input int ack_at, input logic [31:0] rd);
    int  sz, stalls, exp_waits;
    bit  mem, mis, go, st, tmo;
    @(posedge clk); #1;
    sz  = op_size(op);
    mem = (sz != 0);
    mis = mem && (a % sz != 0);
    go  = mem && !mis;
    st  = op_is_store(op);
    valid_me = 1'b1; op_me = op; Result_me = a; wdata_me = rt;
    dm_ack = go ? 1'b0 : 1'($urandom % 2);
    dm_rdata = $urandom;
    @(negedge clk);
    check("adel", adel, mem && !st && mis);
    check("ades", ades, mem && st && mis);
    check("stall_idle", stall_me, go);
    if (!go) begin
      @(posedge clk); #1;
      valid_me = 1'b0; dm_ack = 1'b0;
      @(negedge clk);
      check("no_req", dm_req, 1'b0);
      check("do_hold", Do_me, exp_do);
      return;
    end
    tmo       = (ack_at >= TO);
    exp_waits = tmo ? TO : ack_at + 1;
    stalls    = 1;
    @(posedge clk); #1;
    for (int w = 0; w < TO; w++) begin
      dm_ack   = (w == ack_at);
      dm_rdata = (w == ack_at) ? rd : $urandom;
      @(negedge clk);
      check("req", dm_req, 1'b1);
      check("addr", dm_addr, a & 32'hFFFF_FFFC);
      check("be", dm_be, model_be(op, a));
      check("we", dm_we, st);
      if (st) check("wdata", dm_wdata, model_wdata(op, rt));
      if (stall_me) stalls++;
      @(posedge clk); #1;
      dm_ack = 1'b0;
      if (w == ack_at) break;
    end
    if (!st) exp_do = tmo ? 32'h0 : model_load(op, a, rd);
    dm_ack = 1'($urandom % 2);
    @(negedge clk);
    check("stall_cycles", stalls, exp_waits + 1);
    check("stall_done", stall_me, 1'b0);
    check("req_done", dm_req, 1'b0);
    check("bus_err", bus_err, tmo);
    check("do_done", Do_me, exp_do);
    @(posedge clk); #1;
    valid_me = 1'b0; dm_ack = 1'b0;
    @(negedge clk);
    check("req_after", dm_req, 1'b0);
    check("bus_err_after", bus_err, 1'b0);
    check("do_after", Do_me, exp_do);
  endtask

  task automatic reset_in_wait();
    @(posedge clk); #1;
    valid_me = 1'b1; op_me = 6'h23; Result_me = 32'h300; wdata_me = 32'h0; dm_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1; valid_me = 1'b0;
    #1;
    check("rst_req", dm_req, 1'b0);
    check("rst_stall", stall_me, 1'b0);
    check("rst_do", Do_me, 32'h0);
    check("rst_addr", dm_addr, 32'h0);
    exp_do = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    dm_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", dm_req, 1'b0);
    check("late_ack_do", Do_me, 32'h0);
    check("late_ack_stall", stall_me, 1'b0);
  endtask

  logic [5:0] mem_ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    #1 rst = 1'b1;
    #1;
    check("reset_req", dm_req, 1'b0);
    check("reset_we", dm_we, 1'b0);
    check("reset_be", dm_be, 4'h0);
    check("reset_wdata", dm_wdata, 32'h0);
    check("reset_do", Do_me, 32'h0);
    check("reset_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn(6'h23, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    check("lw_deadbeef", Do_me, 32'hDEADBEEF);
    run_txn(6'h20, 32'h103, 32'h0, 0, 32'h80123456);
    check("lb_sign", Do_me, 32'hFFFFFF80);
    run_txn(6'h24, 32'h103, 32'h0, 2, 32'h80123456);
    check("lbu_zero", Do_me, 32'h00000080);
    run_txn(6'h29, 32'h202, 32'h0000ABCD, 0, 32'h0);
    run_txn(6'h23, 32'h101, 32'h0, 0, 32'h0);
    run_txn(6'h23, 32'h400, 32'h0, 99, 32'h0);
    check("timeout_do", Do_me, 32'h0);
    run_txn(6'h23, 32'h404, 32'h0, TO - 1, 32'h0BAD_F00D);
    reset_in_wait();
    run_txn(6'h25, 32'h502, 32'h0, 0, 32'h8765_4321);
    check("lhu_hi", Do_me, 32'h00008765);

    for (int i = 0; i < 150; i++) begin
      if ($urandom % 10 < 8) op = mem_ops[$urandom % 8];
      else begin
        op = 6'($urandom);
        if (op_size(op) != 0) op = 6'h00;
      end
      a = $urandom;
      if ($urandom % 2 == 1) a[1:0] = 2'b00;
      run_txn(op, a, $urandom, int'($urandom % 20), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
